// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and limits for the pipelined true dual-port RAM
package ram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rd_mode_t;

  localparam int RD_LAT_MIN    = 1;
  localparam int RD_LAT_MAX    = 4;
  localparam int COLL_CNT_BITS = 16;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// rtl/ram_rd_pipe.sv - per-port read latency and valid pipeline
// Data stages only load when their incoming valid is set, so the output word holds between reads.
module ram_rd_pipe #(
  parameter int DATA_BITS = 64,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_valid,
  output logic [DATA_BITS-1:0] o_data
);

  logic [RD_LAT-1:0]    r_vld;
  logic [DATA_BITS-1:0] r_dat [RD_LAT];
  logic [RD_LAT-1:0]    w_vin;
  logic [DATA_BITS-1:0] w_din [RD_LAT];

  always_comb begin
    w_vin[0] = i_valid;
    w_din[0] = i_data;
    for (int i = 1; i < RD_LAT; i++) begin
      w_vin[i] = r_vld[i-1];
      w_din[i] = r_dat[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_dat[i] <= '0;
      end
    end else begin
      r_vld <= w_vin;
      for (int i = 0; i < RD_LAT; i++) begin
        if (w_vin[i]) begin
          r_dat[i] <= w_din[i];
        end
      end
    end
  end

  assign o_valid = r_vld[RD_LAT-1];
  assign o_data  = r_dat[RD_LAT-1];

endmodule

// File: rtl/ram_tdp_pipe_c.sv
// rtl/ram_tdp_pipe_c.sv - true dual-port byte-writable RAM with pipelined reads and conflict counter
// Port A owns overlapping byte lanes when both ports write one address in the same cycle.
module ram_tdp_pipe_c
  import ram_pkg::*;
#(
  parameter int       ADDR_BITS = 10,
  parameter int       DATA_BITS = 64,
  parameter int       RD_LAT    = 2,
  parameter rd_mode_t A_MODE    = READ_FIRST,
  parameter rd_mode_t B_MODE    = READ_FIRST
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_en,
  input  logic [DATA_BITS/8-1:0]   a_we,
  input  logic [ADDR_BITS-1:0]     a_addr,
  input  logic [DATA_BITS-1:0]     a_data_in,
  output logic [DATA_BITS-1:0]     a_data_out,
  output logic                     a_valid,
  input  logic                     b_en,
  input  logic [DATA_BITS/8-1:0]   b_we,
  input  logic [ADDR_BITS-1:0]     b_addr,
  input  logic [DATA_BITS-1:0]     b_data_in,
  output logic [DATA_BITS-1:0]     b_data_out,
  output logic                     b_valid,
  output logic                     collision,
  output logic [COLL_CNT_BITS-1:0] coll_cnt
);

  localparam int NB    = DATA_BITS / 8;
  localparam int DEPTH = 2 ** ADDR_BITS;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("ram_tdp_pipe_c: RD_LAT out of range");
  end
  if ((DATA_BITS % 8) != 0 || DATA_BITS < 8) begin : g_bad_data_bits
    $error("ram_tdp_pipe_c: DATA_BITS must be a positive multiple of 8");
  end

  function automatic logic [DATA_BITS-1:0] f_merge(
    input logic [DATA_BITS-1:0] old_word,
    input logic [DATA_BITS-1:0] new_word,
    input logic [NB-1:0]        lanes
  );
    logic [DATA_BITS-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lanes[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  (* ram_style = "block" *) logic [DATA_BITS-1:0] r_mem [DEPTH];

  logic [NB-1:0]            w_a_wr;
  logic [NB-1:0]            w_b_wr;
  logic                     w_same_addr;
  logic [DATA_BITS-1:0]     w_a_old;
  logic [DATA_BITS-1:0]     w_b_old;
  logic [DATA_BITS-1:0]     w_a_word;
  logic [DATA_BITS-1:0]     w_b_word;
  logic [DATA_BITS-1:0]     w_a_rd;
  logic [DATA_BITS-1:0]     w_b_rd;
  logic                     w_b_store;
  logic                     w_conflict;
  logic                     r_collision;
  logic [COLL_CNT_BITS-1:0] r_coll_cnt;

  // Writes are dropped while reset is held; the array itself is never cleared.
  assign w_a_wr      = a_we & {NB{a_en & ~rst}};
  assign w_b_wr      = b_we & {NB{b_en & ~rst}};
  assign w_same_addr = (a_addr == b_addr);

  assign w_a_old = r_mem[a_addr];
  assign w_b_old = r_mem[b_addr];

  assign w_b_word  = f_merge(w_b_old, b_data_in, w_b_wr);
  assign w_a_word  = f_merge((w_same_addr ? w_b_word : w_a_old), a_data_in, w_a_wr);
  assign w_b_store = (|w_b_wr) && !(w_same_addr && (|w_a_wr));

  always_ff @(posedge clk) begin
    if (w_b_store) begin
      r_mem[b_addr] <= w_b_word;
    end
    if (|w_a_wr) begin
      r_mem[a_addr] <= w_a_word;
    end
  end

  // Only a port's own write is visible to its read; the other port's write never is.
  assign w_a_rd = (A_MODE == WRITE_FIRST) ? f_merge(w_a_old, a_data_in, w_a_wr) : w_a_old;
  assign w_b_rd = (B_MODE == WRITE_FIRST) ? f_merge(w_b_old, b_data_in, w_b_wr) : w_b_old;

  ram_rd_pipe #(
    .DATA_BITS (DATA_BITS),
    .RD_LAT    (RD_LAT)
  ) u_a_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (a_en),
    .i_data  (w_a_rd),
    .o_valid (a_valid),
    .o_data  (a_data_out)
  );

  ram_rd_pipe #(
    .DATA_BITS (DATA_BITS),
    .RD_LAT    (RD_LAT)
  ) u_b_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (b_en),
    .i_data  (w_b_rd),
    .o_valid (b_valid),
    .o_data  (b_data_out)
  );

  assign w_conflict = a_en && b_en && w_same_addr && ((|a_we) || (|b_we));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_collision <= 1'b0;
      r_coll_cnt  <= '0;
    end else begin
      r_collision <= w_conflict;
      if (w_conflict && (r_coll_cnt != '1)) begin
        r_coll_cnt <= r_coll_cnt + COLL_CNT_BITS'(1);
      end
    end
  end

  assign collision = r_collision;
  assign coll_cnt  = r_coll_cnt;

endmodule
